// File: rtl/acc_pkg.sv
// Shared definitions for the acc_pipe accumulator pipeline.
// Contents:
//   MODE_C1 / MODE_ORI / MODE_RELU : bit positions inside the 3-bit per-beat mode
//   MODE_W                         : width of the mode field
//   acc_aw()                       : full-precision accumulator width for a lane
package acc_pkg;

    localparam int MODE_C1   = 0;   // add the 1x1 branch
    localparam int MODE_ORI  = 1;   // add the identity branch
    localparam int MODE_RELU = 2;   // clamp negative sums to zero
    localparam int MODE_W    = 3;

    // CHNL_NUM 3x3 slices plus up to two extra branches are summed, so the
    // sum needs clog2(CHNL_NUM+2) guard bits above the input width.
    function automatic int acc_aw(input int dw, input int chnl);
        return dw + $clog2(chnl + 2);
    endfunction

endpackage

// File: rtl/acc_pipe_if.sv
// Bundle of the acc_pipe input (valid/ready + partial sums + mode) and
// output (valid/ready + result + saturation flags) streams.
// Modports:
//   master : the side that produces input beats and consumes output beats
//   slave  : the acc_pipe side
interface acc_pipe_if
    import acc_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DP       = 56,
    parameter int CHNL_NUM = 3,
    parameter int OW       = 32
);

    logic                       valid_i;
    logic                       ready_o;
    logic [MODE_W-1:0]          mode_i;
    logic [CHNL_NUM*DP*DW-1:0]  data_i_conv3;
    logic [DP*DW-1:0]           data_i_conv1;
    logic [DP*DW-1:0]           data_i_ori;

    logic                       valid_o;
    logic                       ready_i;
    logic [DP*OW-1:0]           data_o;
    logic [DP-1:0]              sat_o;

    modport master (
        output valid_i, mode_i, data_i_conv3, data_i_conv1, data_i_ori, ready_i,
        input  ready_o, valid_o, data_o, sat_o
    );

    modport slave (
        input  valid_i, mode_i, data_i_conv3, data_i_conv1, data_i_ori, ready_i,
        output ready_o, valid_o, data_o, sat_o
    );

endinterface

// File: rtl/acc_lane.sv
// One output lane of the accumulator pipeline: three register stages holding
// the raw inputs (S1), the full-precision sum (S2) and the ReLU'd, saturated
// result (S3). Stage load enables come from the shared pipeline control.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en_s1/en_s2/en_s3    load enable of each stage register
//   conv3_i              CHNL_NUM slices of this lane, slice c at c*DW +: DW
//   conv1_i, ori_i       1x1 and identity branch inputs of this lane
//   add_c1_i, add_ori_i  branch selects of the beat currently in S1
//   relu_i               ReLU select of the beat currently in S2
//   data_o, sat_o        S3 result and saturation flag
module acc_lane
    import acc_pkg::*;
#(
    parameter int DW       = 32,
    parameter int CHNL_NUM = 3,
    parameter int OW       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_s1,
    input  logic                     en_s2,
    input  logic                     en_s3,
    input  logic [CHNL_NUM*DW-1:0]   conv3_i,
    input  logic [DW-1:0]            conv1_i,
    input  logic [DW-1:0]            ori_i,
    input  logic                     add_c1_i,
    input  logic                     add_ori_i,
    input  logic                     relu_i,
    output logic [OW-1:0]            data_o,
    output logic                     sat_o
);

    localparam int AW = acc_aw(DW, CHNL_NUM);
    // Compare in a width that holds both the sum and the output range.
    localparam int EW = (AW > OW) ? AW : OW;

    localparam logic signed [EW-1:0] MAX_V = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [CHNL_NUM*DW-1:0] conv3_q, conv3_d;
    logic [DW-1:0]          conv1_q, conv1_d;
    logic [DW-1:0]          ori_q,   ori_d;
    logic signed [AW-1:0]   sum_q,   sum_d;
    logic [OW-1:0]          data_q,  data_d;
    logic                   sat_q,   sat_d;

    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   relu_v;
    logic signed [EW-1:0]   ext_v;
    logic [OW-1:0]          clip_v;
    logic                   clip_sat;

    function automatic logic signed [AW-1:0] sext(input logic [DW-1:0] x);
        return {{(AW-DW){x[DW-1]}}, x};
    endfunction

    always_comb begin
        // S1: capture raw inputs
        conv3_d = en_s1 ? conv3_i : conv3_q;
        conv1_d = en_s1 ? conv1_i : conv1_q;
        ori_d   = en_s1 ? ori_i   : ori_q;

        // S2: full-precision sum; AW guard bits make overflow impossible
        acc = '0;
        for (int c = 0; c < CHNL_NUM; c++) begin
            acc = acc + sext(conv3_q[c*DW +: DW]);
        end
        if (add_c1_i) begin
            acc = acc + sext(conv1_q);
        end
        if (add_ori_i) begin
            acc = acc + sext(ori_q);
        end
        sum_d = en_s2 ? acc : sum_q;

        // S3: ReLU first, then clamp to the signed OW range
        relu_v = (relu_i && sum_q[AW-1]) ? '0 : sum_q;
        ext_v  = EW'(relu_v);
        if (ext_v > MAX_V) begin
            clip_v   = MAX_V[OW-1:0];
            clip_sat = 1'b1;
        end else if (ext_v < MIN_V) begin
            clip_v   = MIN_V[OW-1:0];
            clip_sat = 1'b1;
        end else begin
            clip_v   = ext_v[OW-1:0];
            clip_sat = 1'b0;
        end
        data_d = en_s3 ? clip_v   : data_q;
        sat_d  = en_s3 ? clip_sat : sat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv3_q <= '0;
            conv1_q <= '0;
            ori_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            conv3_q <= conv3_d;
            conv1_q <= conv1_d;
            ori_q   <= ori_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/acc_pipe.sv
// Three-stage partial-sum accumulator with valid/ready flow control.
// Each beat carries CHNL_NUM 3x3 partial sums, an optional 1x1 branch and an
// optional identity branch for DP lanes; the result is ReLU'd on request and
// saturated to OW bits. Latency 3 cycles, one beat per cycle.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset; discards every in-flight beat
//   bus  acc_pipe_if slave modport (input stream, mode, output stream)
module acc_pipe
    import acc_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DP       = 56,
    parameter int CHNL_NUM = 3,
    parameter int OW       = 32
) (
    input  logic        clk,
    input  logic        rst,
    acc_pipe_if.slave   bus
);

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s3_valid_q, s3_valid_d;
    logic [MODE_W-1:0] mode_s1_q,  mode_s1_d;
    logic              relu_s2_q,  relu_s2_d;

    logic s1_adv;
    logic s2_adv;
    logic s3_adv;

    // A stage takes a new beat when it is empty or its own beat moves on.
    always_comb begin
        s3_adv = !s3_valid_q || bus.ready_i;
        s2_adv = !s2_valid_q || s3_adv;
        s1_adv = !s1_valid_q || s2_adv;

        s1_valid_d = s1_adv ? bus.valid_i : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q  : s2_valid_q;
        s3_valid_d = s3_adv ? s2_valid_q  : s3_valid_q;

        // Mode follows its beat: the branch selects are consumed by S2,
        // only the ReLU bit is needed one stage further.
        mode_s1_d = s1_adv ? bus.mode_i            : mode_s1_q;
        relu_s2_d = s2_adv ? mode_s1_q[MODE_RELU]  : relu_s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            mode_s1_q  <= '0;
            relu_s2_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            mode_s1_q  <= mode_s1_d;
            relu_s2_q  <= relu_s2_d;
        end
    end

    assign bus.ready_o = s1_adv;
    assign bus.valid_o = s3_valid_q;

    generate
        for (genvar gi = 0; gi < DP; gi++) begin : g_lane
            logic [CHNL_NUM*DW-1:0] conv3_lane;
            logic [OW-1:0]          lane_data;
            logic                   lane_sat;

            // Gather this lane's word out of every channel slice.
            for (genvar gc = 0; gc < CHNL_NUM; gc++) begin : g_chnl
                assign conv3_lane[gc*DW +: DW] = bus.data_i_conv3[DW*(gc*DP+gi) +: DW];
            end

            acc_lane #(
                .DW       (DW),
                .CHNL_NUM (CHNL_NUM),
                .OW       (OW)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .en_s1     (s1_adv),
                .en_s2     (s2_adv),
                .en_s3     (s3_adv),
                .conv3_i   (conv3_lane),
                .conv1_i   (bus.data_i_conv1[DW*gi +: DW]),
                .ori_i     (bus.data_i_ori[DW*gi +: DW]),
                .add_c1_i  (mode_s1_q[MODE_C1]),
                .add_ori_i (mode_s1_q[MODE_ORI]),
                .relu_i    (relu_s2_q),
                .data_o    (lane_data),
                .sat_o     (lane_sat)
            );

            assign bus.data_o[OW*gi +: OW] = lane_data;
            assign bus.sat_o[gi]           = lane_sat;
        end
    endgenerate

endmodule

// File: tb/tb_acc_pipe.sv
module tb_acc_pipe;

    localparam int DW       = 32;
    localparam int DP       = 56;
    localparam int CHNL_NUM = 3;
    localparam int OW       = 32;

    typedef logic [DP*OW-1:0] dvec_t;

    typedef struct {
        logic [2:0]  mode;
        logic [31:0] c0, c1, c2, cx, ori;
        int          step;
        logic [31:0] base;
        logic        sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    acc_pipe_if #(.DW(DW), .DP(DP), .CHNL_NUM(CHNL_NUM), .OW(OW)) bus ();

    acc_pipe #(.DW(DW), .DP(DP), .CHNL_NUM(CHNL_NUM), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // lane l value = base + step*l
    function automatic dvec_t ramp(input logic [31:0] base, input int step);
        dvec_t v;
        v = '0;
        for (int l = 0; l < DP; l++) begin
            v[l*OW +: OW] = base + 32'(step * l);
        end
        return v;
    endfunction

    task automatic chk(input string name, input dvec_t act, input dvec_t exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int l = DP - 1; l >= 0; l--) begin
                if (act[l*OW +: OW] !== exp[l*OW +: OW]) bad = l;
            end
            $display("FAIL %s: word %0d got %h expected %h", name, bad,
                     act[bad*OW +: OW], exp[bad*OW +: OW]);
        end
    endtask

    // slice0, conv1 and ori get +step*l per lane so lane mapping is exercised
    task automatic drive(input logic [2:0] mode, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] cx, input logic [31:0] ori,
                         input int step);
        bus.mode_i = mode;
        for (int l = 0; l < DP; l++) begin
            bus.data_i_conv3[DW*(0*DP+l) +: DW] = c0 + 32'(step * l);
            bus.data_i_conv3[DW*(1*DP+l) +: DW] = c1;
            bus.data_i_conv3[DW*(2*DP+l) +: DW] = c2;
            bus.data_i_conv1[DW*l +: DW]        = cx + 32'(step * l);
            bus.data_i_ori[DW*l +: DW]          = ori + 32'(step * l);
        end
    endtask

    vec_t vecs[14];

    initial begin
        int k;
        int next_in, next_out, inflight, n_out;
        logic stall_prev;
        dvec_t prev_data;
        logic [31:0] base;
        logic odd;

        //        mode     c0            c1            c2            conv1         ori           step base          sat
        vecs[0]  = '{3'b011, 32'd1,        32'd2,        32'd3,        32'd4,        32'd5,        1, 32'd15,        1'b0};
        vecs[1]  = '{3'b000, 32'd1,        32'd2,        32'd3,        32'd4,        32'd5,        1, 32'd6,         1'b0};
        vecs[2]  = '{3'b100, -32'sd10,     -32'sd10,     -32'sd10,     32'd4,        32'd5,        0, 32'd0,         1'b0};
        vecs[3]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,        32'd0,        0, 32'h7FFFFFFF,  1'b1};
        vecs[4]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h80000000, 32'd0,        32'd0,        0, 32'h80000000,  1'b1};
        vecs[5]  = '{3'b001, -32'sd1,      -32'sd2,      -32'sd3,      32'd4,        32'd5,        2, 32'hFFFFFFFE,  1'b0};
        vecs[6]  = '{3'b110, -32'sd10,     32'd0,        32'd0,        32'd0,        32'd5,        0, 32'd0,         1'b0};
        vecs[7]  = '{3'b111, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        0, 32'h7FFFFFFF,  1'b1};
        vecs[8]  = '{3'b010, 32'h80000000, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 0, 32'h80000000,  1'b1};
        vecs[9]  = '{3'b100, 32'd5,        32'd0,        32'd0,        32'd0,        32'd0,        1, 32'd5,         1'b0};
        vecs[10] = '{3'b000, 32'h7FFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        0, 32'h7FFFFFFF,  1'b0};
        vecs[11] = '{3'b000, 32'h80000000, 32'd0,        32'd0,        32'd0,        32'd0,        0, 32'h80000000,  1'b0};
        vecs[12] = '{3'b000, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        0, 32'h7FFFFFFF,  1'b1};
        vecs[13] = '{3'b110, -32'sd10,     32'd0,        32'd0,        32'd0,        32'd15,       0, 32'd5,         1'b0};

        // ---------------- reset state ----------------
        bus.valid_i      = 1'b0;
        bus.ready_i      = 1'b1;
        bus.mode_i       = '0;
        bus.data_i_conv3 = '0;
        bus.data_i_conv1 = '0;
        bus.data_i_ori   = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid_o", dvec_t'(bus.valid_o), dvec_t'(1'b0));
        chk("rst_data_o",  bus.data_o, '0);
        chk("rst_sat_o",   dvec_t'(bus.sat_o), '0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_o", dvec_t'(bus.ready_o), dvec_t'(1'b1));
        chk("post_rst_valid_o", dvec_t'(bus.valid_o), dvec_t'(1'b0));

        // ---------------- table vectors, one beat at a time ----------------
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].mode, vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].cx, vecs[i].ori, vecs[i].step);
            bus.valid_i = 1'b1;
            #1;
            chk("vec_ready_o", dvec_t'(bus.ready_o), dvec_t'(1'b1));
            @(negedge clk);            // accepted on the edge just passed
            bus.valid_i = 1'b0;
            chk("vec_lat1_valid", dvec_t'(bus.valid_o), dvec_t'(1'b0));
            @(negedge clk);
            chk("vec_lat2_valid", dvec_t'(bus.valid_o), dvec_t'(1'b0));
            @(negedge clk);
            chk("vec_lat3_valid", dvec_t'(bus.valid_o), dvec_t'(1'b1));
            k = vecs[i].step * (1 + int'(vecs[i].mode[0]) + int'(vecs[i].mode[1]));
            chk("vec_data", bus.data_o, ramp(vecs[i].base, k));
            chk("vec_sat", dvec_t'(bus.sat_o), vecs[i].sat ? dvec_t'({DP{1'b1}}) : dvec_t'(0));
            $display("vec %0d mode=%b lane0=%h sat=%b", i, vecs[i].mode, bus.data_o[OW-1:0], bus.sat_o[0]);
        end

        // ---------------- 10-beat stream, ready_i pattern 1,0,0,1 ----------------
        next_in    = 1;
        next_out   = 1;
        inflight   = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 200 && next_out <= 10; cyc++) begin
            @(negedge clk);
            bus.ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (next_in <= 10) begin
                // odd beats add a 1x1 branch of 100+l, even beats do not
                drive((next_in % 2 == 1) ? 3'b001 : 3'b000, 32'(next_in), 32'd0, 32'd0, 32'd100, 32'd0, 1);
                bus.valid_i = 1'b1;
            end else begin
                bus.valid_i = 1'b0;
            end
            #1;
            chk("stream_ready_o", dvec_t'(bus.ready_o), dvec_t'(!(inflight == 3 && !bus.ready_i)));
            if (stall_prev) begin
                chk("stall_valid_o", dvec_t'(bus.valid_o), dvec_t'(1'b1));
                chk("stall_data_o", bus.data_o, prev_data);
            end
            if (bus.valid_o && bus.ready_i) begin
                odd  = (next_out % 2 == 1);
                base = 32'(next_out) + (odd ? 32'd100 : 32'd0);
                chk("stream_data", bus.data_o, ramp(base, odd ? 2 : 1));
                $display("stream out beat %0d lane0=%h", next_out, bus.data_o[OW-1:0]);
                next_out++;
                inflight--;
            end
            if (bus.valid_i && bus.ready_o) begin
                next_in++;
                inflight++;
            end
            stall_prev = bus.valid_o && !bus.ready_i;
            prev_data  = bus.data_o;
        end
        chk("stream_count", dvec_t'(next_out - 1), dvec_t'(10));
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("stream_no_extra", dvec_t'(bus.valid_o), dvec_t'(1'b0));

        // ---------------- reset with three beats in flight ----------------
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(3'b000, 32'(50 + i), 32'd0, 32'd0, 32'd0, 32'd0, 1);
            bus.valid_i = 1'b1;
            #1;
            chk("fill_ready_o", dvec_t'(bus.ready_o), dvec_t'(1'b1));
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        chk("full_ready_o", dvec_t'(bus.ready_o), dvec_t'(1'b0));
        chk("full_valid_o", dvec_t'(bus.valid_o), dvec_t'(1'b1));
        chk("full_data_o", bus.data_o, ramp(32'd50, 1));
        rst = 1'b1;
        #1;
        chk("midrst_valid_o", dvec_t'(bus.valid_o), dvec_t'(1'b0));
        chk("midrst_data_o", bus.data_o, '0);
        chk("midrst_sat_o", dvec_t'(bus.sat_o), '0);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        drive(3'b000, 32'd77, 32'd0, 32'd0, 32'd0, 32'd0, 1);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        n_out = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (bus.valid_o) begin
                n_out++;
                chk("postrst_data", bus.data_o, ramp(32'd77, 1));
                $display("post-reset out lane0=%h", bus.data_o[OW-1:0]);
            end
            @(negedge clk);
        end
        chk("postrst_count", dvec_t'(n_out), dvec_t'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acc_pipe.md
ACC_PIPE -- requirements
Module: acc_pipe

Interface
REQ-001 Parameter DW, default 32, signed two's-complement width of each input partial sum.
REQ-002 Parameter DP, default 56, lanes (output pixels) processed in parallel.
REQ-003 Parameter CHNL_NUM, default 3, number of 3x3 partial-sum slices per beat.
REQ-004 Parameter OW, default 32, signed output width per lane; OW <= DW+3 SHALL hold.
REQ-005 clk  input  1  single clock; one clock; reset is asynchronous and active-high.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 valid_i  input  1  input beat valid.
REQ-008 ready_o  output  1  block can accept an input beat this cycle.
REQ-009 mode_i  input  3  per-beat mode, sampled with the beat: bit0 add conv1, bit1 add identity, bit2 ReLU.
REQ-010 data_i_conv3  input  CHNL_NUM*DP*DW  slice c, lane l at bits DW*(c*DP+l) +: DW.
REQ-011 data_i_conv1  input  DP*DW  1x1 branch, lane l at DW*l +: DW.
REQ-012 data_i_ori  input  DP*DW  identity branch, lane l at DW*l +: DW.
REQ-013 valid_o  output  1  output beat valid.
REQ-014 ready_i  input  1  downstream accepts output beat.
REQ-015 data_o  output  DP*OW  result, lane l at OW*l +: OW.
REQ-016 sat_o  output  DP  per-lane flag: the lane saturated in the current output beat.

Function
REQ-017 Input beat transfers on clk rising edge when valid_i and ready_o are both 1; output beat transfers when valid_o and ready_i are both 1.
REQ-018 Per lane: sum = sum over c of conv3[c] + (mode bit0 ? conv1 : 0) + (mode bit1 ? ori : 0), sign-extended, accumulator width AW = DW + clog2(CHNL_NUM+2); no intermediate overflow.
REQ-019 Stage S1 registers all inputs and mode; S2 registers the full-width sum; S3 applies ReLU (negative -> 0) if mode bit2, then saturates to OW signed range, registers data_o and sat_o.
REQ-020 Latency: an accepted beat appears on valid_o exactly 3 cycles later when ready_i held 1; throughput one beat per cycle.
REQ-021 Each stage holds a valid bit; a stage advances when it is empty or its successor advances; ready_o = !S1_valid or S1 advances.
REQ-022 With ready_i = 0 and all three stages full, ready_o SHALL be 0 and data_o/sat_o/valid_o SHALL stay stable; no beat dropped or duplicated.
REQ-023 Saturation: sum > 2^(OW-1)-1 -> 2^(OW-1)-1 with sat_o[l]=1; sum < -2^(OW-1) -> -2^(OW-1) with sat_o[l]=1; else sat_o[l]=0; ReLU is applied before saturation.
REQ-024 Beats leave in acceptance order; mode travels with its beat, so mode changes between consecutive beats take effect per beat.
REQ-025 Data registers of empty stages need not hold defined values, but valid_o SHALL be 0 whenever S3 is empty.

Reset
REQ-026 On rst=1, all stage valid bits, data_o and sat_o clear to 0 immediately; valid_o=0, ready_o=1 after reset deasserts.
REQ-027 Reset mid-operation discards all in-flight beats; no output beat from pre-reset input appears afterward.

Structure
REQ-028 Shared package acc_pkg holds mode bit indices (MODE_C1=0, MODE_ORI=1, MODE_RELU=2) and the AW width function.
REQ-029 One sub-module acc_lane implements one lane's sum, ReLU and saturation datapath; acc_pipe instantiates DP copies and owns the valid/ready control.

Verification
REQ-030 DP=56, CHNL_NUM=3, mode=3'b011, conv3 slices 1,2,3, conv1=4, ori=5 all lanes, ready_i=1 -> data_o lanes = 15, sat_o=0, valid_o 3 cycles after acceptance.
REQ-031 Same data, mode=3'b000 -> 6; mode=3'b100 with conv3 = -10,-10,-10 -> 0, sat_o=0.
REQ-032 OW=32, conv3 = 0x7FFFFFFF x3, mode=3'b000 -> 0x7FFFFFFF, sat_o all 1; three 0x80000000 -> 0x80000000, sat_o all 1.
REQ-033 Stream 10 beats numbered 1..10 with ready_i toggled 1,0,0,1 pattern -> exactly 10 output beats, in order, values unchanged while stalled, ready_o=0 only when all stages full.
REQ-034 Assert rst for one cycle with 3 beats in flight -> valid_o=0 and data_o=0 immediately; next beat after reset emerges alone with correct value.
